// File: rtl/snake_dir_if.sv
// snake_dir_if: control inputs and status outputs of the snake direction controller.
interface snake_dir_if;
    logic       clk_slow;
    logic [3:0] btn_in;
    logic       run;
    logic [1:0] speed;
    logic       tick;
    logic [3:0] btn_db;
    logic [1:0] dir;
    logic       step;
    modport master (output clk_slow, btn_in, run, speed, input tick, btn_db, dir, step);
    modport slave (input clk_slow, btn_in, run, speed, output tick, btn_db, dir, step);
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: slow-clock tick, button debounce, direction arbitration and step pacing.
module snake_dir_ctrl #(
    parameter int DEB_TICKS  = 4,
    parameter int STEP_TICKS = 25
) (
    input logic        clk_ht,
    input logic        rst_n,
    snake_dir_if.slave bus
);
    localparam int DW = $clog2(DEB_TICKS) + 1;
    logic          s1, s2, s3, tick, step, req_v, accept;
    logic [3:0]    b1, b2, btn_db, btn_q, rise;
    logic [DW-1:0] deb_cnt [4];
    logic [1:0]    dir, pend, req, nxt_pend;
    logic [7:0]    cnt, p_raw, p;
    assign tick  = s2 & ~s3;
    assign rise  = btn_db & ~btn_q;
    assign req_v = |rise;
    assign req   = rise[3] ? 2'b00 : rise[2] ? 2'b01 : rise[1] ? 2'b10 : 2'b11;
    // opposite directions differ only in bit 0
    assign accept   = req_v && (req != dir) && ((req ^ dir) != 2'b01);
    assign nxt_pend = accept ? req : pend;
    assign p_raw    = 8'(STEP_TICKS) >> bus.speed;
    assign p        = (p_raw == 8'd0) ? 8'd1 : p_raw;
    always_ff @(posedge clk_ht) begin
        if (!rst_n) begin
            {s1, s2, s3} <= '0;
            b1           <= '0;
            b2           <= '0;
            btn_q        <= '0;
        end else begin
            {s1, s2, s3} <= {bus.clk_slow, s1, s2};
            b1           <= bus.btn_in;
            b2           <= b1;
            btn_q        <= btn_db;
        end
    end
    always_ff @(posedge clk_ht) begin
        if (!rst_n) begin
            btn_db <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (b2[i] == btn_db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_TICKS - 1)) begin
                    btn_db[i]  <= ~btn_db[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end
    // a request accepted in the firing cycle is forwarded straight into dir
    always_ff @(posedge clk_ht) begin
        if (!rst_n) begin
            dir  <= 2'b11;
            pend <= 2'b11;
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            pend <= nxt_pend;
            step <= 1'b0;
            if (tick && bus.run) begin
                if (cnt >= p - 8'd1) begin
                    cnt  <= '0;
                    dir  <= nxt_pend;
                    step <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
    assign bus.tick   = tick;
    assign bus.btn_db = btn_db;
    assign bus.dir    = dir;
    assign bus.step   = step;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed checks of tick, debounce, step pacing, direction rules and reset.
module tb_snake_dir_ctrl;
    logic clk_ht = 1'b0;
    logic rst_n  = 1'b0;
    int tests = 0, fails = 0;
    int tick_cnt = 0, step_cnt = 0, dbl = 0, s0 = 0, t0 = 0;
    logic tick_prev = 1'b0, step_prev = 1'b0;
    snake_dir_if bus ();
    snake_dir_ctrl #(.DEB_TICKS(4), .STEP_TICKS(8)) dut (.clk_ht(clk_ht), .rst_n(rst_n), .bus(bus));
    always #5 clk_ht = ~clk_ht;
    always @(posedge clk_ht) begin
        if (bus.tick === 1'b1) tick_cnt++;
        if (bus.step === 1'b1) step_cnt++;
        if ((bus.tick && tick_prev) || (bus.step && step_prev)) dbl++;
        tick_prev = bus.tick;
        step_prev = bus.step;
    end
    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic slow(input int n);
        repeat (n) begin
            bus.clk_slow = 1'b1;
            repeat (10) @(negedge clk_ht);
            bus.clk_slow = 1'b0;
            repeat (10) @(negedge clk_ht);
        end
    endtask
    task automatic press(input logic [3:0] b);
        bus.btn_in = b;
        slow(4);
    endtask
    task automatic one_step;
        s0 = step_cnt;
        bus.run = 1'b1;
        slow(1);
        bus.run = 1'b0;
        chk("one_step", step_cnt - s0, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end
    initial begin
        bus.clk_slow = 1'b0;
        bus.btn_in   = 4'b1111;
        bus.run      = 1'b1;
        bus.speed    = 2'd3;
        repeat (5) begin
            @(negedge clk_ht);
            chk("rst_dir", int'(bus.dir), 3);
            chk("rst_step", int'(bus.step), 0);
            chk("rst_btn_db", int'(bus.btn_db), 0);
            chk("rst_tick", int'(bus.tick), 0);
            bus.clk_slow = ~bus.clk_slow;
        end
        bus.clk_slow = 1'b0;
        bus.btn_in   = 4'b0000;
        bus.run      = 1'b0;
        bus.speed    = 2'd0;
        rst_n        = 1'b1;
        repeat (3) @(negedge clk_ht);
        t0 = tick_cnt;
        bus.clk_slow = 1'b1;
        @(negedge clk_ht);
        chk("tick_k", int'(bus.tick), 0);
        @(negedge clk_ht);
        chk("tick_k1", int'(bus.tick), 1);
        @(negedge clk_ht);
        chk("tick_k2", int'(bus.tick), 0);
        repeat (7) @(negedge clk_ht);
        bus.clk_slow = 1'b0;
        repeat (10) @(negedge clk_ht);
        slow(3);
        chk("tick_count", tick_cnt - t0, 4);
        chk("tick_width", dbl, 0);
        bus.btn_in = 4'b1000;
        slow(3);
        bus.btn_in = 4'b0000;
        slow(2);
        chk("deb_short", int'(bus.btn_db), 0);
        bus.btn_in = 4'b1000;
        slow(3);
        chk("deb_3ticks", int'(bus.btn_db), 0);
        slow(1);
        chk("deb_4ticks", int'(bus.btn_db), 8);
        bus.btn_in = 4'b0000;
        slow(3);
        chk("deb_rel3", int'(bus.btn_db), 8);
        slow(1);
        chk("deb_rel4", int'(bus.btn_db), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_ht);
        rst_n = 1'b1;
        bus.run   = 1'b1;
        bus.speed = 2'd0;
        s0 = step_cnt;
        slow(7);
        chk("p8_early", step_cnt - s0, 0);
        slow(1);
        chk("p8_fire", step_cnt - s0, 1);
        chk("pend_discarded", int'(bus.dir), 3);
        bus.speed = 2'd2;
        s0 = step_cnt;
        slow(4);
        chk("p2_steps", step_cnt - s0, 2);
        bus.speed = 2'd3;
        s0 = step_cnt;
        slow(3);
        chk("p1_steps", step_cnt - s0, 3);
        bus.speed = 2'd0;
        s0 = step_cnt;
        slow(5);
        chk("cnt5_nostep", step_cnt - s0, 0);
        bus.speed = 2'd2;
        slow(1);
        chk("speedup_fire", step_cnt - s0, 1);
        bus.run   = 1'b0;
        bus.speed = 2'd3;
        press(4'b0010);
        chk("left_db", int'(bus.btn_db), 2);
        press(4'b0000);
        one_step();
        chk("left_rejected", int'(bus.dir), 3);
        press(4'b0100);
        press(4'b0000);
        press(4'b0010);
        press(4'b0000);
        one_step();
        chk("down_then_left", int'(bus.dir), 1);
        press(4'b1001);
        chk("upright_db", int'(bus.btn_db), 9);
        press(4'b0000);
        one_step();
        chk("up_opposite", int'(bus.dir), 1);
        bus.speed = 2'd0;
        bus.run   = 1'b1;
        s0 = step_cnt;
        slow(3);
        bus.run = 1'b0;
        slow(20);
        chk("pause_nostep", step_cnt - s0, 0);
        bus.run = 1'b1;
        slow(4);
        chk("resume_early", step_cnt - s0, 0);
        slow(1);
        chk("resume_fire", step_cnt - s0, 1);
        bus.run   = 1'b0;
        bus.speed = 2'd3;
        press(4'b0001);
        press(4'b0000);
        one_step();
        chk("right_accept", int'(bus.dir), 3);
        press(4'b1000);
        press(4'b0000);
        bus.speed = 2'd0;
        bus.run   = 1'b1;
        slow(3);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_ht);
        chk("midrst_dir", int'(bus.dir), 3);
        rst_n = 1'b1;
        s0 = step_cnt;
        slow(7);
        chk("midrst_cnt_early", step_cnt - s0, 0);
        slow(1);
        chk("midrst_cnt_fire", step_cnt - s0, 1);
        chk("midrst_pend", int'(bus.dir), 3);
        chk("step_width", dbl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Game-pace and direction controller for the snake core. It consumes the slow square wave from the 100 Hz clock divider as a data signal and turns it into a one-cycle tick in the `clk_ht` domain. It debounces the four direction buttons on that tick and emits a `step` pulse at a speed-selectable rate. The snake movement logic advances by one cell per `step`, using the direction on `dir`.

## Interface
- `DEB_TICKS`, default 4: consecutive tick samples that must disagree with the debounced level before it flips (≥1).
- `STEP_TICKS`, default 25: ticks per move at speed 0 (≥1, ≤255).
- `clk_ht`  in  1: system clock; the only clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `clk_slow`  in  1: divider output (≈100 Hz square wave); treated as asynchronous data.
- `btn_in`  in  4: raw buttons, active-high; [3]=up, [2]=down, [1]=left, [0]=right.
- `run`  in  1: 1 = step generation enabled; 0 = paused.
- `speed`  in  2: speed level 0..3.
- `tick`  out  1: one-cycle pulse per `clk_slow` rising edge.
- `btn_db`  out  4: debounced button levels.
- `dir`  out  2: committed direction; 00 up, 01 down, 10 left, 11 right.
- `step`  out  1: one-cycle move pulse.

## Operation
- **Reset** (`rst_n`=0 at a `clk_ht` edge): all registers clear except the direction registers. `dir`=11 and `pend`=11. `tick`, `step`, `btn_db`, sync registers, debounce counters and the step counter are all 0. Reset mid-operation discards any pending direction and partial counts.
- **Tick.** `clk_slow` passes through a 2-FF synchronizer (s1, s2) and a delay register s3. `tick` = s2 & ~s3 (combinational).
- **Button sync.** Each `btn_in` bit passes through its own 2-FF synchronizer.
- **Debounce**, per bit, evaluated only on a tick:
  - If the synced value equals `btn_db[i]`, the counter resets to 0.
  - Otherwise, if the counter equals DEB_TICKS-1, `btn_db[i]` flips and the counter resets to 0.
  - Otherwise the counter increments.
  - Counter width is clog2(DEB_TICKS)+1.
- **Direction request.** A request is a rising edge on a `btn_db` bit, detected against a one-cycle-delayed copy.
  - If several bits rise in the same cycle, priority is up > down > left > right.
  - A request is rejected if it equals `dir` or is the opposite of `dir` (up/down, left/right).
  - An accepted request overwrites `pend`; the last accepted request before a step wins.
  - The opposite check uses committed `dir`, not `pend`.
- **Step generation.**
  - Period P = max(1, STEP_TICKS >> `speed`), computed combinationally each cycle.
  - On a tick with `run`=1:
    - If cnt ≥ P-1: cnt ← 0, `dir` ← `pend`, `step` ← 1.
    - Otherwise cnt increments.
  - `step` is registered and returns to 0 on the next cycle.
  - Using ≥ means a speed increase mid-count fires on the next tick.
  - Counter width is 8 bits.
- **Pause.** With `run`=0, cnt holds and `step` stays 0. Debounce and `pend` updates continue.

## Timing
- `clk_slow` sampled high first at edge k: s1=1 after k, s2=1 after k+1. `tick` is high for exactly the one cycle between edges k+1 and k+2.
- `clk_slow` high at reset release produces one tick under the same rule.
- `btn_db` changes at the clock edge ending the DEB_TICKS-th consecutive disagreeing tick.
- The request is evaluated in the cycle after `btn_db` changes; `pend` updates at the following edge.
- A request accepted before or in the same cycle as a firing tick is committed by that step (`pend` compare is 1-cycle registered). A request arriving later waits for the next step.
- `dir` and `step` update at the same edge; the new `dir` is valid in the cycle `step` is high.
- Step latency: `step` goes high 1 cycle after the firing tick. Steps are spaced exactly P ticks apart at constant speed.

## Test plan
- **Reset.** Hold `rst_n`=0 for 5 cycles while `clk_slow` toggles and buttons are pressed.
  -> `dir`=11, `step`=0, `btn_db`=0000, `tick`=0 throughout reset.
- **Tick.** `clk_slow` period 20 cycles (scaled).
  -> exactly one 1-cycle `tick` per rising edge, 2 edges after first sample; no tick on falling edges.
- **Debounce** (DEB_TICKS=4).
  - Up held for 3 ticks, then released -> `btn_db[3]` stays 0.
  - Up held for 4 ticks -> `btn_db[3]`=1 at the 4th tick.
  - Release for 4 ticks -> `btn_db[3]`=0.
- **Period** (STEP_TICKS=8, `run`=1).
  - `speed`=0 -> `step` every 8 ticks; `speed`=2 -> every 2; `speed`=3 -> every tick.
  - Switch 0→2 at cnt=5 -> `step` on the next tick.
- **Direction** (`dir`=11).
  - Press left -> rejected; `dir` stays 11 after the next step.
  - Press down, then left before the step -> `dir`=01.
  - Press up and right simultaneously (from `dir`=01 they are up: opposite, right: valid) -> up rejected by the opposite rule, since the priority encoder selects up first. Required result: no change, `dir` stays 01.
- **Pause and reset.**
  - `run`=0 for 20 ticks -> no `step`, cnt frozen; resume -> next step after the remaining ticks.
  - `rst_n` pulsed low mid-count with `pend`=00 -> `dir`=11, cnt=0, `pend`=11.
